// File: rtl/uart_tx.sv
// UART transmitter: a one-entry holding register feeds a start/data/parity/stop
// bit engine that advances once per baud tick and drives a registered TXD line.
module uart_tx #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              txen,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  input  logic              par_en,
  input  logic              par_odd,
  output logic              txd,
  output logic              busy
);

  localparam int                IDX_W     = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic                txd_q, txd_d;
  logic                hold_full_q, hold_full_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic                hold_par_en_q, hold_par_en_d;
  logic                hold_par_odd_q, hold_par_odd_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                load;

  always_comb begin
    // NOTE: every *_d starts as its *_q, so no branch below can leave one unassigned and infer a latch.
    state_d        = state_q;
    txd_d          = txd_q;
    hold_full_d    = hold_full_q;
    hold_data_d    = hold_data_q;
    hold_par_en_d  = hold_par_en_q;
    hold_par_odd_d = hold_par_odd_q;
    shift_d        = shift_q;
    par_en_d       = par_en_q;
    par_bit_d      = par_bit_q;
    bit_idx_d      = bit_idx_q;
    stop_cnt_d     = stop_cnt_q;
    load           = 1'b0;

    if (valid && !hold_full_q) begin
      hold_full_d    = 1'b1;
      hold_data_d    = data;
      hold_par_en_d  = par_en;
      hold_par_odd_d = par_odd;
    end

    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (txen && hold_full_q) load = 1'b1;
      end
      S_START: if (txen) begin
        state_d   = S_DATA;
        bit_idx_d = '0;
        txd_d     = shift_q[0];
        shift_d   = shift_q >> 1;
      end
      S_DATA: if (txen) begin
        if (bit_idx_q != LAST_IDX) begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
        end else if (par_en_q) begin
          state_d = S_PARITY;
          txd_d   = par_bit_q;
        end else begin
          state_d    = S_STOP;
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      S_PARITY: if (txen) begin
        state_d    = S_STOP;
        txd_d      = 1'b1;
        stop_cnt_d = 1'b0;
      end
      S_STOP: if (txen) begin
        if (stop_cnt_q != LAST_STOP) stop_cnt_d = stop_cnt_q + 1'b1;
        else if (hold_full_q)        load       = 1'b1;
        else                         state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Parity is fixed at load time so the held byte can be replaced mid-frame.
    if (load) begin
      state_d     = S_START;
      txd_d       = 1'b0;
      shift_d     = hold_data_q;
      par_en_d    = hold_par_en_q;
      par_bit_d   = (^hold_data_q) ^ hold_par_odd_q;
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      txd_q          <= 1'b1;
      hold_full_q    <= 1'b0;
      hold_data_q    <= '0;
      hold_par_en_q  <= 1'b0;
      hold_par_odd_q <= 1'b0;
      shift_q        <= '0;
      par_en_q       <= 1'b0;
      par_bit_q      <= 1'b0;
      bit_idx_q      <= '0;
      stop_cnt_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge *_d values together.
      state_q        <= state_d;
      txd_q          <= txd_d;
      hold_full_q    <= hold_full_d;
      hold_data_q    <= hold_data_d;
      hold_par_en_q  <= hold_par_en_d;
      hold_par_odd_q <= hold_par_odd_d;
      shift_q        <= shift_d;
      par_en_q       <= par_en_d;
      par_bit_q      <= par_bit_d;
      bit_idx_q      <= bit_idx_d;
      stop_cnt_q     <= stop_cnt_d;
    end
  end

  assign ready = !hold_full_q;
  assign busy  = (state_q != S_IDLE) || hold_full_q;
  assign txd   = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line-level receiver model decodes TXD and
// compares each frame with one built from the frame-format rules.
module tb_uart_tx;

  localparam int DW0 = 8;
  localparam int SB0 = 1;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst, txen;
  logic [7:0] data0;
  logic       valid0, par_en0, par_odd0, ready0, txd0, busy0;
  logic [6:0] data1;
  logic       valid1, par_en1, par_odd1, ready1, txd1, busy1;

  uart_tx #(.DATA_W(8), .STOP_BITS(1)) dut0 (
    .clk(clk), .n_rst(n_rst), .txen(txen), .data(data0), .valid(valid0),
    .ready(ready0), .par_en(par_en0), .par_odd(par_odd0), .txd(txd0), .busy(busy0)
  );

  uart_tx #(.DATA_W(7), .STOP_BITS(2)) dut1 (
    .clk(clk), .n_rst(n_rst), .txen(txen), .data(data1), .valid(valid1),
    .ready(ready1), .par_en(par_en1), .par_odd(par_odd1), .txd(txd1), .busy(busy1)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       po;
  } cfg_t;

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        po;
    logic [15:0] exp_bits;  // bit i = i-th bit period on the line
    int          exp_len;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;

  cfg_t exp_q[$];
  logic cap1[$];
  bit   cap1_on = 1'b0;

  int   txen_per = 16;
  int   txen_cnt = 0;
  bit   txen_rand = 1'b0;
  bit   acc0, acc1;
  logic prev_txd, prev_txd1;

  bit          rx_active = 1'b0;
  int          rx_cnt, rx_need;
  logic [15:0] rx_bits;
  cfg_t        rx_cfg;
  int          rx_frames = 0;
  int          rx_gap = 0, rx_last_gap = 0;
  logic [15:0] rx_last_bits;
  int          rx_last_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame built straight from the format: start, data LSB first, parity, stops.
  function automatic logic [15:0] model_frame(input logic [7:0] d, input logic pe,
                                              input logic po, output int len);
    logic [15:0] f;
    int n;
    f = '0;
    n = 1;
    for (int i = 0; i < DW0; i++) begin
      f[n] = d[i];
      n++;
    end
    if (pe) begin
      f[n] = (($countones(d) % 2) == 1) ^ po;
      n++;
    end
    for (int i = 0; i < SB0; i++) begin
      f[n] = 1'b1;
      n++;
    end
    len = n;
    return f;
  endfunction

  task automatic rx_sample(input logic b);
    logic [15:0] m;
    int mlen;
    if (!rx_active) begin
      if (b == 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", exp_q.size(), 1);
          rx_cfg = '0;
        end else begin
          rx_cfg = exp_q.pop_front();
        end
        rx_active   = 1'b1;
        rx_bits     = '0;
        rx_cnt      = 1;
        rx_need     = 1 + DW0 + int'(rx_cfg.pe) + SB0;
        rx_last_gap = rx_gap;
        rx_gap      = 0;
      end else begin
        rx_gap++;
      end
    end else begin
      rx_bits[rx_cnt] = b;
      rx_cnt++;
      if (rx_cnt == rx_need) begin
        m = model_frame(rx_cfg.d, rx_cfg.pe, rx_cfg.po, mlen);
        check("frame_bits", rx_bits, m);
        rx_active    = 1'b0;
        rx_frames++;
        rx_last_bits = rx_bits;
        rx_last_len  = rx_cnt;
      end
    end
  endtask

  // One clock: record handshakes, advance, sample outputs #1 after the edge.
  task automatic step();
    logic en_e, rst_e, acc0_e, acc1_e;
    cfg_t c;
    en_e   = txen;
    rst_e  = n_rst;
    acc0_e = valid0 && ready0;
    acc1_e = valid1 && ready1;
    if (rst_e && acc0_e) begin
      c.d  = data0;
      c.pe = par_en0;
      c.po = par_odd0;
      exp_q.push_back(c);
    end
    @(posedge clk);
    #1;
    acc0 = rst_e && acc0_e;
    acc1 = rst_e && acc1_e;
    if (!rst_e) begin
      exp_q.delete();
      rx_active = 1'b0;
      rx_gap    = 0;
    end else if (!en_e) begin
      check("txd0_stable", txd0, prev_txd);
      check("txd1_stable", txd1, prev_txd1);
    end else begin
      rx_sample(txd0);
      if (cap1_on) cap1.push_back(txd1);
    end
    prev_txd  = txd0;
    prev_txd1 = txd1;
    if (txen_rand) begin
      txen = ($urandom_range(0, 2) == 0);
    end else begin
      txen_cnt = (txen_cnt >= txen_per - 1) ? 0 : txen_cnt + 1;
      txen     = (txen_cnt == 0);
    end
  endtask

  task automatic send0(input logic [7:0] d, input logic pe, input logic po, input bit keep);
    int t;
    data0 = d; par_en0 = pe; par_odd0 = po; valid0 = 1'b1;
    t = 0;
    do begin
      step();
      t++;
    end while (!acc0 && t < 2000);
    check("accept_seen", acc0, 1'b1);
    if (!keep) begin
      valid0   = 1'b0;
      data0    = 8'($urandom);
      par_en0  = 1'($urandom);
      par_odd0 = 1'($urandom);
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    int t;
    t = 0;
    while (rx_frames < target && t < budget) begin
      step();
      t++;
    end
    check("frames_done", rx_frames >= target, 1'b1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy0 || rx_active) && t < 3000) begin
      step();
      t++;
    end
    check("idle_reached", busy0 || rx_active, 1'b0);
  endtask

  initial begin
    vec_t        tbl[6];
    int          base, t;
    logic [20:0] got1;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 16'h034A, 10};
    tbl[1] = '{8'h07, 1'b1, 1'b0, 16'h060E, 11};
    tbl[2] = '{8'h07, 1'b1, 1'b1, 16'h040E, 11};
    tbl[3] = '{8'h00, 1'b1, 1'b0, 16'h0400, 11};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 16'h07FE, 11};
    tbl[5] = '{8'h80, 1'b0, 1'b0, 16'h0300, 10};

    n_rst = 1'b0; txen = 1'b0;
    valid0 = 1'b0; data0 = '0; par_en0 = 1'b0; par_odd0 = 1'b0;
    valid1 = 1'b0; data1 = '0; par_en1 = 1'b0; par_odd1 = 1'b0;
    repeat (3) step();
    n_rst = 1'b1;
    step();
    check("rst_txd0", txd0, 1'b1);
    check("rst_ready0", ready0, 1'b1);
    check("rst_busy0", busy0, 1'b0);
    check("rst_txd1", txd1, 1'b1);
    check("rst_ready1", ready1, 1'b1);

    // Single 0xA5 frame: handshake timing, frame duration, busy release.
    send0(8'hA5, 1'b0, 1'b0, 1'b0);
    check("a5_ready_held", ready0, 1'b0);
    check("a5_busy_held", busy0, 1'b1);
    t = 0;
    while (txd0 !== 1'b0 && t < 100) begin
      step();
      t++;
    end
    check("a5_start_bit", txd0, 1'b0);
    check("a5_ready_after_load", ready0, 1'b1);
    t = 0;
    while (busy0 && t < 400) begin
      step();
      t++;
    end
    check("a5_frame_clks", t, 160);
    check("a5_idle_txd", txd0, 1'b1);
    check("a5_bits", rx_last_bits, 16'h034A);

    // Table of single frames with hand-derived line patterns.
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      base = rx_frames;
      send0(tbl[i].d, tbl[i].pe, tbl[i].po, 1'b0);
      wait_frames(base + 1, 2000);
      check($sformatf("tbl%0d_bits", i), rx_last_bits, tbl[i].exp_bits);
      check($sformatf("tbl%0d_len", i), rx_last_len, tbl[i].exp_len);
    end

    // Back-to-back: second byte held during the first frame, no idle gap.
    wait_idle();
    base = rx_frames;
    send0(8'h55, 1'b0, 1'b0, 1'b1);
    send0(8'h0F, 1'b0, 1'b0, 1'b0);
    check("b2b_ready_held", ready0, 1'b0);
    check("b2b_busy_held", busy0, 1'b1);
    repeat (5) step();
    check("b2b_ready_still_held", ready0, 1'b0);
    wait_frames(base + 2, 2000);
    check("b2b_gap", rx_last_gap, 0);

    // Backpressure: valid held across three bytes.
    wait_idle();
    base = rx_frames;
    send0(8'h11, 1'b0, 1'b0, 1'b1);
    send0(8'h22, 1'b1, 1'b0, 1'b1);
    send0(8'h33, 1'b1, 1'b1, 1'b0);
    wait_frames(base + 3, 3000);
    check("bp_frames", rx_frames - base, 3);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset during data bit 3 with a second byte held.
    wait_idle();
    send0(8'h96, 1'b0, 1'b0, 1'b1);
    send0(8'h5A, 1'b0, 1'b0, 1'b0);
    t = 0;
    while (!(rx_active && rx_cnt == 5) && t < 2000) begin
      step();
      t++;
    end
    check("rst_at_bit3", rx_cnt, 5);
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    check("midrst_txd", txd0, 1'b1);
    check("midrst_ready", ready0, 1'b1);
    check("midrst_busy", busy0, 1'b0);
    base = rx_frames;
    send0(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_frames(base + 1, 2000);
    check("post_rst_bits", rx_last_bits, 16'h0278);
    repeat (300) step();
    check("post_rst_no_extra", rx_frames, base + 1);
    check("post_rst_busy", busy0, 1'b0);

    // DATA_W=7, STOP_BITS=2: 0x41 then 0x22 back-to-back.
    cap1_on = 1'b1;
    data1 = 7'h41; valid1 = 1'b1;
    t = 0;
    do begin
      step();
      t++;
    end while (!acc1 && t < 500);
    check("dw7_accept1", acc1, 1'b1);
    cap1.delete();
    data1 = 7'h22;
    t = 0;
    do begin
      step();
      t++;
    end while (!acc1 && t < 500);
    check("dw7_accept2", acc1, 1'b1);
    valid1 = 1'b0;
    t = 0;
    while (cap1.size() < 21 && t < 1000) begin
      step();
      t++;
    end
    cap1_on = 1'b0;
    check("dw7_samples", cap1.size() >= 21, 1'b1);
    got1 = '0;
    for (int i = 0; i < 21 && i < cap1.size(); i++) got1[i] = cap1[i];
    check("dw7_sb2_trace", got1, 21'h1D1382);

    // Random bytes, parity settings, gaps and irregular baud ticks.
    wait_idle();
    txen_rand = 1'b1;
    base = rx_frames;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 4)) step();
      send0(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
    wait_frames(base + 40, 20000);
    check("rand_frames", rx_frames - base, 40);
    check("rand_queue_empty", exp_q.size(), 0);
    txen_rand = 1'b0;
    wait_idle();
    check("final_ready", ready0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
